// File: rtl/uart_send_src_pkg.sv
// -----------------------------------------------------------------------------
// uart_send_src_pkg
// Shared types and constants for the push-button UART byte source:
//   - state_t  : sequencer states (IDLE, SEND, WAIT, RELEASE)
//   - MSG_LEN  : number of bytes in the canned message
//   - IDX_W    : width of the message byte index
//   - msg_byte : message ROM lookup, "HELLO!\r\n"
// -----------------------------------------------------------------------------
package uart_send_src_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int MSG_LEN = 8;
  localparam int IDX_W   = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  // Message ROM: "HELLO!\r\n"
  function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h48;
      3'd1:    b = 8'h45;
      3'd2:    b = 8'h4C;
      3'd3:    b = 8'h4C;
      3'd4:    b = 8'h4F;
      3'd5:    b = 8'h21;
      3'd6:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_send_src_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchronizer plus consecutive-sample debounce for an active-low key.
// Ports:
//   i_clk   : system clock
//   i_rst   : asynchronous active-high reset (key treated as released)
//   i_key   : raw push button, active low, asynchronous to i_clk
//   o_level : debounced key level (1 = released)
//   o_press : one-cycle pulse on a debounced 1->0 transition
// -----------------------------------------------------------------------------
module key_debounce
  import uart_send_src_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // r_cnt counts consecutive synchronized samples that disagree with the
  // debounced level; the DEBOUNCE_CYCLES-th such sample flips the level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        // Old level high means this flip is a press (1->0).
        r_press <= r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/uart_send_src.sv
// -----------------------------------------------------------------------------
// uart_send_src
// Push-button-triggered byte source for a UART transmitter. A debounced press
// plays the 8-byte message "HELLO!\r\n", one byte per enable strobe, strobes
// spaced BYTE_GAP cycles apart.
// Ports:
//   sys_clk : system clock
//   sys_rst : asynchronous active-high reset
//   key     : push button, active low, asynchronous
//   enable  : one-cycle strobe, dout valid while high
//   dout    : message byte (holds the last byte sent between strobes)
// Handshake: enable is a bare strobe with no ready/back-pressure. The consumer
// must take dout in the strobe cycle and be ready again BYTE_GAP cycles later.
// -----------------------------------------------------------------------------
module uart_send_src
  import uart_send_src_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int BYTE_GAP        = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key,
  output logic       enable,
  output logic [7:0] dout
);

  // r_gap holds at most BYTE_GAP-1.
  localparam int GAP_W = $clog2(BYTE_GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(BYTE_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic w_level;
  logic w_press;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [GAP_W-1:0] r_gap;
  logic             r_enable;
  logic [7:0]       r_dout;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .i_clk  (sys_clk),
    .i_rst  (sys_rst),
    .i_key  (key),
    .o_level(w_level),
    .o_press(w_press)
  );

  // enable/dout are loaded on entry to SEND so the strobe coincides with the
  // SEND cycle. The gap counter runs BYTE_GAP-1 WAIT cycles, which puts
  // successive SEND cycles exactly BYTE_GAP apart.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_gap    <= '0;
      r_enable <= 1'b0;
      r_dout   <= 8'h00;
    end else begin
      r_enable <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_press) begin
            r_state  <= SEND;
            r_enable <= 1'b1;
            r_dout   <= msg_byte(r_idx);
          end
        end
        SEND: begin
          if (r_idx == LAST_IDX) begin
            r_state <= RELEASE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_gap   <= GAP_LOAD;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_gap == GAP_ONE) begin
            r_state  <= SEND;
            r_enable <= 1'b1;
            r_dout   <= msg_byte(r_idx);
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        RELEASE: begin
          // A held key yields one message only; wait for a debounced release.
          if (w_level) begin
            r_idx   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign enable = r_enable;
  assign dout   = r_dout;

endmodule

// File: tb/tb_uart_send_src.sv
module tb_uart_send_src;

  localparam int DB     = 2;
  localparam int GAP_A  = 16;
  localparam int GAP_B  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic key_a, key_b;
  logic en_a, en_b;
  logic [7:0] dout_a, dout_b;

  always #5 clk = ~clk;

  uart_send_src #(.DEBOUNCE_CYCLES(DB), .BYTE_GAP(GAP_A)) dut (
    .sys_clk(clk), .sys_rst(rst), .key(key_a), .enable(en_a), .dout(dout_a)
  );

  uart_send_src #(.DEBOUNCE_CYCLES(DB), .BYTE_GAP(GAP_B)) dut_g2 (
    .sys_clk(clk), .sys_rst(rst), .key(key_b), .enable(en_b), .dout(dout_b)
  );

  logic [7:0] rom [0:7] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21, 8'h0D, 8'h0A};

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle time %0t)", nm, act, exp, $time);
  endtask

  // scoreboard: {strobe cycle, byte}
  logic [39:0] exp_q[$];
  int          cyc = 0;
  int          obs_a = 0;
  logic [7:0]  m_last_b = 8'h00;

  // reference model: synchronized key history, debounced level by the
  // "last DEBOUNCE_CYCLES samples agree" rule, and message scheduling
  initial begin : ref_model
    logic        m_s1, m_s2, m_lvl, all_x;
    logic [15:0] m_win;
    int          m_last_s;
    m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b1; m_win = '1; m_last_s = -100;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b1; m_win = '1; m_last_s = -100;
        exp_q.delete();
      end else begin
        m_win = {m_win[14:0], m_s2};
        m_s2  = m_s1;
        m_s1  = key_a;
        all_x = 1'b1;
        for (int i = 0; i < DB; i++) if (m_win[i] == m_lvl) all_x = 1'b0;
        if (all_x) begin
          m_lvl = ~m_lvl;
          // a press is accepted only once the previous message has ended
          // and RELEASE has had a cycle to see the key up
          if (!m_lvl && cyc >= m_last_s + 2) begin
            for (int k = 0; k < 8; k++) exp_q.push_back({32'(cyc + 1 + k * GAP_A), rom[k]});
            m_last_s = cyc + 1 + 7 * GAP_A;
          end
        end
      end
    end
  end

  // monitor for dut (BYTE_GAP=16)
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_enable", 32'(en_a), 32'd0);
        chk("rst_dout", 32'(dout_a), 32'd0);
        m_last_b = 8'h00;
      end else begin
        if (en_a) obs_a++;
        if (exp_q.size() > 0 && exp_q[0][39:8] == 32'(cyc)) begin
          chk("strobe_enable", 32'(en_a), 32'd1);
          m_last_b = exp_q[0][7:0];
          void'(exp_q.pop_front());
        end else begin
          chk("idle_enable", 32'(en_a), 32'd0);
        end
        chk("dout", 32'(dout_a), 32'(m_last_b));
      end
    end
  end

  // driver tasks
  task automatic press_a(input int n);
    @(negedge clk) key_a = 1'b0;
    repeat (n) @(negedge clk);
    key_a = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n;
    n = 0;
    while (obs_a < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_strobes_in_time", 32'(obs_a >= target), 32'd1);
  endtask

  typedef struct {
    int         low;
    int         strobes;
    logic [7:0] dout;
  } vec_t;

  vec_t vec [5];

  initial begin : test
    int         base;
    int         n_b;
    int         t_b [16];
    logic [7:0] d_b [16];
    logic       lv;

    vec[0] = '{low: 1,   strobes: 0, dout: 8'h00};  // glitch right after reset
    vec[1] = '{low: 3,   strobes: 8, dout: 8'h0A};
    vec[2] = '{low: 2,   strobes: 8, dout: 8'h0A};  // exactly DEBOUNCE_CYCLES
    vec[3] = '{low: 500, strobes: 8, dout: 8'h0A};  // held key: one message
    vec[4] = '{low: 4,   strobes: 8, dout: 8'h0A};  // new press after release

    rst = 1'b1; key_a = 1'b1; key_b = 1'b1;
    idle(3);
    chk("reset_enable", 32'(en_a), 32'd0);
    chk("reset_dout", 32'(dout_a), 32'd0);
    rst = 1'b0;
    idle(5);

    // table-driven key patterns
    for (int t = 0; t < 5; t++) begin
      base = obs_a;
      press_a(vec[t].low);
      idle(200);
      chk("vec_strobes", 32'(obs_a - base), 32'(vec[t].strobes));
      chk("vec_dout_after", 32'(dout_a), 32'(vec[t].dout));
    end

    // second press after the 3rd strobe is ignored
    base = obs_a;
    press_a(3);
    wait_strobes(base + 3, 200);
    idle(2);
    press_a(4);
    idle(250);
    chk("repress_strobes", 32'(obs_a - base), 32'd8);

    // reset after the 4th strobe
    base = obs_a;
    press_a(3);
    wait_strobes(base + 4, 200);
    idle(3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_enable", 32'(en_a), 32'd0);
    chk("rst_mid_dout", 32'(dout_a), 32'd0);
    idle(2);
    rst = 1'b0;
    base = obs_a;
    idle(200);
    chk("post_rst_quiet", 32'(obs_a - base), 32'd0);
    press_a(3);
    idle(200);
    chk("post_rst_msg", 32'(obs_a - base), 32'd8);

    // randomized key activity: glitches, short presses, long holds
    lv = 1'b1;
    for (int s = 0; s < 40; s++) begin
      lv = ~lv;
      @(negedge clk) key_a = lv;
      if (s % 3 == 0) idle($urandom_range(1, 150));
      else idle($urandom_range(1, 6));
    end
    @(negedge clk) key_a = 1'b1;
    idle(300);

    // BYTE_GAP=2 instance: strobes every other cycle, 15-cycle message
    n_b = 0;
    for (int i = 0; i < 16; i++) begin t_b[i] = 0; d_b[i] = 8'h00; end
    @(negedge clk) key_b = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 2) key_b = 1'b1;
      if (en_b) begin
        if (n_b < 16) begin t_b[n_b] = c; d_b[n_b] = dout_b; end
        n_b++;
      end
    end
    chk("g2_strobes", 32'(n_b), 32'd8);
    for (int k = 0; k < 8; k++) chk("g2_byte", 32'(d_b[k]), 32'(rom[k]));
    for (int k = 1; k < 8; k++) chk("g2_spacing", 32'(t_b[k] - t_b[k-1]), 32'd2);
    chk("g2_span", 32'(t_b[7] - t_b[0] + 1), 32'd15);
    chk("g2_dout_after", 32'(dout_b), 32'h0A);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
